// File: rtl/gcu_pkg.sv
// Shared types and constants for the GCU sequencing controller.
// Lane count and element width must match the GCU datapath.
package gcu_pkg;

  localparam int GCU_W          = 64;
  localparam int GCU_LANES      = 32;
  localparam int GCU_ADDR_W     = 12;
  localparam int GCU_LEN_W      = 12;
  localparam int GCU_FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } gcu_state_e;

  typedef logic signed [GCU_W-1:0] gcu_vec_t [GCU_LANES];

endpackage

// File: rtl/gcu_res_fifo.sv
// Result FIFO: synchronous, no write-through, sync active-low reset.
// Ports: i_push/i_din write, i_pop read, o_dout head entry, o_count occupancy.
module gcu_res_fifo
  import gcu_pkg::*;
#(
  parameter int DEPTH = GCU_FIFO_DEPTH,
  parameter int DW    = GCU_W * GCU_LANES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_din,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_dout,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH-1);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [PTR_W-1:0] r_wp;
  logic [PTR_W-1:0] r_rp;
  logic [CNT_W-1:0] r_cnt;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= nxt(r_wp);
      if (i_pop)  r_rp <= nxt(r_rp);
      unique case ({i_push, i_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_dout  = r_mem[r_rp];
  assign o_count = r_cnt;

endmodule

// File: rtl/gcu_sched.sv
// GCU sequencing controller: streams vectors src->GCU->dst with
// credit-based flow control around a small result FIFO.
// Ports: start/src_base/dst_base/num_vec command, busy/done status,
// rd_en/rd_addr/rd_data source read, gcu_x/gcu_y GCU link,
// wr_valid/wr_ready/wr_addr/wr_data destination write.
module gcu_sched
  import gcu_pkg::*;
#(
  parameter int W          = GCU_W,
  parameter int NUM_GELU   = GCU_LANES,
  parameter int ADDR_W     = GCU_ADDR_W,
  parameter int LEN_W      = GCU_LEN_W,
  parameter int FIFO_DEPTH = GCU_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_W-1:0]       src_base,
  input  logic [ADDR_W-1:0]       dst_base,
  input  logic [LEN_W-1:0]        num_vec,
  output logic                    busy,
  output logic                    done,
  output logic                    rd_en,
  output logic [ADDR_W-1:0]       rd_addr,
  input  logic [W*NUM_GELU-1:0]   rd_data,
  output logic [W*NUM_GELU-1:0]   gcu_x,
  input  logic [W*NUM_GELU-1:0]   gcu_y,
  output logic                    wr_valid,
  input  logic                    wr_ready,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [W*NUM_GELU-1:0]   wr_data
);

  localparam int DW    = W * NUM_GELU;
  localparam int CNT_W = $clog2(FIFO_DEPTH+1);
  localparam logic [LEN_W:0] ONE = (LEN_W+1)'(1);
  localparam logic [CNT_W:0] MAXC = (CNT_W+1)'(FIFO_DEPTH);

  gcu_state_e r_state;
  gcu_state_e w_state_nxt;

  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_num;
  logic [LEN_W:0]    r_issued;
  logic [LEN_W:0]    r_written;
  logic              r_inflight;

  logic [LEN_W:0]    w_num;
  logic [CNT_W-1:0]  w_count;
  logic [CNT_W:0]    w_credits;
  logic              w_accept;
  logic              w_rd;
  logic              w_pop;
  logic              w_last_rd;
  logic              w_last_wr;

  assign w_num     = {1'b0, r_num};
  assign w_accept  = (r_state == IDLE) && start;
  // A read in flight already owns a FIFO slot.
  assign w_credits = {1'b0, w_count} + (CNT_W+1)'(r_inflight);
  assign w_rd      = (r_state == RUN) && (r_issued != w_num)
                   && (w_credits < MAXC);
  assign w_last_rd = w_rd && (r_issued + ONE == w_num);
  assign w_pop     = wr_valid && wr_ready;
  assign w_last_wr = w_pop && (r_written + ONE == w_num);

  assign busy     = (r_state == RUN) || (r_state == DRAIN);
  assign done     = (r_state == DONE);
  assign rd_en    = w_rd;
  assign rd_addr  = r_src + ADDR_W'(r_issued);
  assign gcu_x    = rd_data;
  assign wr_valid = (w_count != '0);
  assign wr_addr  = r_dst + ADDR_W'(r_written);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (start) w_state_nxt = (num_vec == '0) ? DONE : RUN;
      end
      RUN: begin
        if (w_last_rd) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_last_wr) w_state_nxt = DONE;
      end
      DONE: w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_num      <= '0;
      r_issued   <= '0;
      r_written  <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      if (w_accept) begin
        r_src     <= src_base;
        r_dst     <= dst_base;
        r_num     <= num_vec;
        r_issued  <= '0;
        r_written <= '0;
      end else begin
        if (w_rd)  r_issued  <= r_issued + ONE;
        if (w_pop) r_written <= r_written + ONE;
      end
    end
  end

  // rd_data is valid the cycle after rd_en; gcu_y is captured then.
  gcu_res_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_din   (gcu_y),
    .i_pop   (w_pop),
    .o_dout  (wr_data),
    .o_count (w_count)
  );

endmodule

// File: tb/tb_gcu_sched.sv
// Directed testbench for gcu_sched with a source memory model and
// a behavioural GCU model (per lane y = 3*x + lane).
module tb_gcu_sched;

  localparam int DW = 64 * 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [11:0]   src_base;
  logic [11:0]   dst_base;
  logic [11:0]   num_vec;
  logic          busy;
  logic          done;
  logic          rd_en;
  logic [11:0]   rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] gcu_x;
  logic [DW-1:0] gcu_y;
  logic          wr_valid;
  logic          wr_ready;
  logic [11:0]   wr_addr;
  logic [DW-1:0] wr_data;

  int checks = 0;
  int errors = 0;

  gcu_sched dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .src_base (src_base),
    .dst_base (dst_base),
    .num_vec  (num_vec),
    .busy     (busy),
    .done     (done),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .gcu_x    (gcu_x),
    .gcu_y    (gcu_y),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] src_vec(input logic [11:0] a);
    logic [DW-1:0] v;
    for (int i = 0; i < 32; i++)
      v[i*64 +: 64] = {4'hC, a, 8'(i), 40'h12_3456_789A};
    return v;
  endfunction

  function automatic logic [DW-1:0] gcu_model(input logic [DW-1:0] x);
    logic [DW-1:0] y;
    logic [63:0]   lx;
    for (int i = 0; i < 32; i++) begin
      lx = x[i*64 +: 64];
      y[i*64 +: 64] = lx * 64'd3 + 64'(i);
    end
    return y;
  endfunction

  always_comb gcu_y = gcu_model(gcu_x);

  always @(posedge clk) begin
    if (rd_en) rd_data <= src_vec(rd_addr);
    else       rd_data <= '0;
  end

  int            rd_cyc[$];
  logic [11:0]   rd_a[$];
  int            wr_cyc[$];
  logic [11:0]   wr_a[$];
  logic [DW-1:0] wr_d[$];
  int            done_cyc[$];
  int            busy_cnt;
  int            valid_cnt;
  int            stab_err;
  logic          p_hold;
  logic [11:0]   p_a;
  logic [DW-1:0] p_d;
  logic          s_busy, s_done, s_rd_en, s_wr_valid;
  logic [11:0]   s_rd_addr, s_wr_addr;

  task automatic run_job(
    input logic [11:0] s, input logic [11:0] d,
    input logic [11:0] n, input int ncyc,
    input int stall_lo, input int stall_hi,
    input int s2_cyc, input int rst_cyc
  );
    rd_cyc.delete(); rd_a.delete();
    wr_cyc.delete(); wr_a.delete(); wr_d.delete();
    done_cyc.delete();
    busy_cnt = 0; valid_cnt = 0; stab_err = 0; p_hold = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      start = (c == 0) || (c == s2_cyc);
      if (c == 0) begin
        src_base = s; dst_base = d; num_vec = n;
      end else if (c == s2_cyc) begin
        src_base = 12'h200; dst_base = 12'h300; num_vec = 12'd7;
      end
      rst_n    = (c != rst_cyc);
      wr_ready = !(c >= stall_lo && c <= stall_hi);
      #1;
      if (rd_en) begin rd_cyc.push_back(c); rd_a.push_back(rd_addr); end
      if (wr_valid && wr_ready) begin
        wr_cyc.push_back(c); wr_a.push_back(wr_addr);
        wr_d.push_back(wr_data);
      end
      if (done) done_cyc.push_back(c);
      if (busy) busy_cnt++;
      if (wr_valid) valid_cnt++;
      if (p_hold && (!wr_valid || wr_addr !== p_a || wr_data !== p_d))
        stab_err++;
      p_hold = wr_valid && !wr_ready;
      p_a = wr_addr; p_d = wr_data;
      if (c == rst_cyc + 1) begin
        s_busy = busy; s_done = done; s_rd_en = rd_en;
        s_rd_addr = rd_addr; s_wr_valid = wr_valid; s_wr_addr = wr_addr;
      end
    end
    start = 1'b0; rst_n = 1'b1; wr_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; wr_ready = 1'b1;
    src_base = 12'h0; dst_base = 12'h0; num_vec = 12'h0;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++;
      $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin errors++;
      $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (rd_en !== 1'b0) begin errors++;
      $display("FAIL reset_rd_en got %b exp 0", rd_en); end
    checks++; if (rd_addr !== 12'h0) begin errors++;
      $display("FAIL reset_rd_addr got %h exp 000", rd_addr); end
    checks++; if (wr_valid !== 1'b0) begin errors++;
      $display("FAIL reset_wr_valid got %b exp 0", wr_valid); end
    checks++; if (wr_addr !== 12'h0) begin errors++;
      $display("FAIL reset_wr_addr got %h exp 000", wr_addr); end
    checks++; if (gcu_x !== rd_data) begin errors++;
      $display("FAIL reset_gcu_x got %h exp %h", gcu_x[63:0], rd_data[63:0]); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    logic [DW-1:0] e;
    run_job(12'h010, 12'h100, 12'd4, 12, -1, -1, -1, -1);
    checks++; if (rd_cyc.size() !== 4) begin errors++;
      $display("FAIL basic_nreads got %0d exp 4", rd_cyc.size()); end
    for (int k = 0; k < 4 && k < rd_cyc.size(); k++) begin
      checks++; if (rd_a[k] !== 12'h010 + 12'(k) || rd_cyc[k] !== 1 + k) begin
        errors++;
        $display("FAIL basic_rd%0d got %h@%0d exp %h@%0d",
                 k, rd_a[k], rd_cyc[k], 12'h010 + 12'(k), 1 + k);
      end
    end
    checks++; if (wr_cyc.size() !== 4) begin errors++;
      $display("FAIL basic_nwrites got %0d exp 4", wr_cyc.size()); end
    for (int k = 0; k < 4 && k < wr_cyc.size(); k++) begin
      e = gcu_model(src_vec(12'h010 + 12'(k)));
      checks++; if (wr_a[k] !== 12'h100 + 12'(k) || wr_cyc[k] !== 3 + k) begin
        errors++;
        $display("FAIL basic_wr%0d got %h@%0d exp %h@%0d",
                 k, wr_a[k], wr_cyc[k], 12'h100 + 12'(k), 3 + k);
      end
      checks++; if (wr_d[k] !== e) begin errors++;
        $display("FAIL basic_data%0d got %h exp %h", k, wr_d[k][63:0], e[63:0]);
      end
    end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 7) begin errors++;
      $display("FAIL basic_done got n=%0d first=%0d exp n=1 at 7",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_zero_len;
    run_job(12'h055, 12'h155, 12'd0, 6, -1, -1, -1, -1);
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 1) begin errors++;
      $display("FAIL zero_done got n=%0d first=%0d exp n=1 at 1",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
    checks++; if (rd_cyc.size() !== 0 || valid_cnt !== 0) begin errors++;
      $display("FAIL zero_traffic got reads=%0d valid=%0d exp 0 0",
               rd_cyc.size(), valid_cnt);
    end
    checks++; if (busy_cnt !== 0) begin errors++;
      $display("FAIL zero_busy got %0d exp 0", busy_cnt); end
  endtask

  task automatic test_backpressure;
    logic [DW-1:0] e;
    int early;
    run_job(12'h020, 12'h100, 12'd8, 24, 3, 10, -1, -1);
    early = 0;
    foreach (rd_cyc[k]) if (rd_cyc[k] <= 11) early++;
    checks++; if (early !== 3) begin errors++;
      $display("FAIL bp_stall_reads got %0d exp 3", early); end
    checks++; if (rd_cyc.size() < 4 || rd_cyc[3] !== 12) begin errors++;
      $display("FAIL bp_resume got %0d exp 12",
               rd_cyc.size() >= 4 ? rd_cyc[3] : -1);
    end
    checks++; if (stab_err !== 0) begin errors++;
      $display("FAIL bp_stable got %0d exp 0", stab_err); end
    checks++; if (valid_cnt < 8 + 8) begin errors++;
      $display("FAIL bp_valid_held got %0d exp >=16", valid_cnt); end
    checks++; if (wr_cyc.size() !== 8) begin errors++;
      $display("FAIL bp_nwrites got %0d exp 8", wr_cyc.size()); end
    for (int k = 0; k < 8 && k < wr_cyc.size(); k++) begin
      e = gcu_model(src_vec(12'h020 + 12'(k)));
      checks++;
      if (wr_a[k] !== 12'h100 + 12'(k) || wr_d[k] !== e || wr_cyc[k] !== 11 + k)
      begin
        errors++;
        $display("FAIL bp_wr%0d got %h@%0d d=%h exp %h@%0d d=%h", k, wr_a[k],
                 wr_cyc[k], wr_d[k][63:0], 12'h100 + 12'(k), 11 + k, e[63:0]);
      end
    end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 19) begin errors++;
      $display("FAIL bp_done got n=%0d first=%0d exp n=1 at 19",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_wrap;
    logic [11:0] er [3];
    logic [11:0] ew [3];
    er = '{12'hFFE, 12'hFFF, 12'h000};
    ew = '{12'hFFF, 12'h000, 12'h001};
    run_job(12'hFFE, 12'hFFF, 12'd3, 10, -1, -1, -1, -1);
    checks++; if (rd_a.size() !== 3 || wr_a.size() !== 3) begin errors++;
      $display("FAIL wrap_counts got r=%0d w=%0d exp 3 3",
               rd_a.size(), wr_a.size());
    end
    for (int k = 0; k < 3 && k < rd_a.size() && k < wr_a.size(); k++) begin
      checks++; if (rd_a[k] !== er[k] || wr_a[k] !== ew[k]) begin errors++;
        $display("FAIL wrap_%0d got rd=%h wr=%h exp rd=%h wr=%h",
                 k, rd_a[k], wr_a[k], er[k], ew[k]);
      end
    end
    checks++;
    if (wr_d.size() < 3 || wr_d[2] !== gcu_model(src_vec(12'h000))) begin
      errors++;
      $display("FAIL wrap_data got %h exp %h",
               wr_d.size() >= 3 ? wr_d[2][63:0] : 64'h0,
               gcu_model(src_vec(12'h000)) & 64'hFFFF_FFFF_FFFF_FFFF);
    end
  endtask

  task automatic test_start_busy;
    run_job(12'h010, 12'h100, 12'd4, 14, -1, -1, 2, -1);
    checks++; if (rd_a.size() !== 4 || wr_a.size() !== 4) begin errors++;
      $display("FAIL sbusy_counts got r=%0d w=%0d exp 4 4",
               rd_a.size(), wr_a.size());
    end
    for (int k = 0; k < 4 && k < rd_a.size() && k < wr_a.size(); k++) begin
      checks++;
      if (rd_a[k] !== 12'h010 + 12'(k) || wr_a[k] !== 12'h100 + 12'(k)) begin
        errors++;
        $display("FAIL sbusy_%0d got rd=%h wr=%h exp rd=%h wr=%h", k,
                 rd_a[k], wr_a[k], 12'h010 + 12'(k), 12'h100 + 12'(k));
      end
    end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 7) begin errors++;
      $display("FAIL sbusy_done got n=%0d first=%0d exp n=1 at 7",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_reset_mid;
    run_job(12'h040, 12'h140, 12'd8, 16, -1, -1, -1, 4);
    checks++;
    if ({s_busy, s_done, s_rd_en, s_wr_valid} !== 4'b0000 ||
        s_rd_addr !== 12'h0 || s_wr_addr !== 12'h0) begin
      errors++;
      $display("FAIL rstmid_outputs got b%b d%b r%b v%b ra=%h wa=%h exp all 0",
               s_busy, s_done, s_rd_en, s_wr_valid, s_rd_addr, s_wr_addr);
    end
    checks++; if (done_cyc.size() !== 0) begin errors++;
      $display("FAIL rstmid_nodone got %0d exp 0", done_cyc.size()); end
    run_job(12'h020, 12'h220, 12'd2, 8, -1, -1, -1, -1);
    checks++;
    if (rd_a.size() !== 2 || wr_a.size() !== 2 ||
        wr_a[0] !== 12'h220 || wr_a[1] !== 12'h221 ||
        wr_cyc[0] !== 3 || wr_cyc[1] !== 4) begin
      errors++;
      $display("FAIL rstmid_fresh got r=%0d w=%0d exp 2 writes 220,221 at 3,4",
               rd_a.size(), wr_a.size());
    end
    checks++;
    if (wr_d.size() < 1 || wr_d[0] !== gcu_model(src_vec(12'h020))) begin
      errors++;
      $display("FAIL rstmid_data got %h exp %h",
               wr_d.size() ? wr_d[0][63:0] : 64'h0,
               gcu_model(src_vec(12'h020)) & 64'hFFFF_FFFF_FFFF_FFFF);
    end
    checks++; if (done_cyc.size() !== 1 || done_cyc[0] !== 5) begin errors++;
      $display("FAIL rstmid_done got n=%0d first=%0d exp n=1 at 5",
               done_cyc.size(), done_cyc.size() ? done_cyc[0] : -1);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_backpressure();
    test_wrap();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcu_sched.md
# gcu_sched

Sequencing controller for the 32-lane GELU compute unit (GCU). On a `start` command it streams `num_vec` 32-element Q48.16 vectors from an activation buffer through the combinational GCU and writes the results to a destination region. The destination side can back-pressure the block through a ready/valid write port. Flow control is credit-based around a small result FIFO, so the GCU runs at one vector per cycle when the writer is always ready.

## Interface
- `W`, 64: element width (Q48.16).
- `NUM_GELU`, 32: lanes per vector; must match the GCU.
- `ADDR_W`, 12: buffer vector-address width.
- `LEN_W`, 12: width of the vector count.
- `FIFO_DEPTH`, 3: result FIFO entries; minimum 3, needed for full throughput.

Ports:
- `clk`  in  1  single clock.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  one-cycle command strobe; sampled only in IDLE.
- `src_base`  in  ADDR_W  first source vector address; latched on an accepted `start`.
- `dst_base`  in  ADDR_W  first destination vector address; latched on an accepted `start`.
- `num_vec`  in  LEN_W  vectors to process; latched on an accepted `start`.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle completion pulse.
- `rd_en`  out  1  source read strobe.
- `rd_addr`  out  ADDR_W  source vector address.
- `rd_data`  in  W×NUM_GELU  source vector; valid exactly 1 cycle after `rd_en`.
- `gcu_x`  out  W×NUM_GELU  GCU input; equals `rd_data`, passed through.
- `gcu_y`  in  W×NUM_GELU  GCU output; combinational function of `gcu_x`.
- `wr_valid`  out  1  result available.
- `wr_ready`  in  1  destination accepts.
- `wr_addr`  out  ADDR_W  destination vector address.
- `wr_data`  out  W×NUM_GELU  result vector; the FIFO head.

## Operation
FSM states are IDLE, RUN, DRAIN and DONE.
- **IDLE.** When `start`=1, latch `src_base`, `dst_base` and `num_vec`, clear `issued`, `written` and the credits. Go to RUN, or to DONE directly if `num_vec`=0. `start` in any other state is ignored.
- **RUN.** Issue a read (`rd_en`=1, `rd_addr`=src_base+issued) when `credits < FIFO_DEPTH`, where `credits` = FIFO occupancy + reads in flight (0 or 1). Then `issued` increments. When the last read issues (`issued` reaches `num_vec`), go to DRAIN on the next cycle.
- **Capture.** The cycle after a read, `rd_data` drives `gcu_x`, and `gcu_y` is pushed into the FIFO at the clock edge. The FIFO never overflows, by the credit rule.
- **Write.** `wr_valid` = FIFO not empty. On `wr_valid && wr_ready`: pop the FIFO, then `written++`. `wr_addr` = dst_base + written.
- **DRAIN.** No reads are issued. When the write handshake that makes `written` = `num_vec` completes, go to DONE.
- **DONE.** `done`=1 for one cycle, then IDLE.
- **Ordering.** Results leave in source order, one write per source vector; no reordering and no drops.
- **Address arithmetic.** Addresses are modulo 2^ADDR_W; src and dst wrap silently.
- **Counters.** `issued` and `written` are LEN_W+1 bits wide; the maximum `num_vec` is 2^LEN_W−1.
- **`wr_valid` stability.** Once `wr_valid` is asserted, `wr_valid`, `wr_addr` and `wr_data` stay stable until the handshake completes.
- **Reset.** Reset mid-operation abandons the job: the FIFO empties, the FSM goes to IDLE, and no `done` is produced.

## Timing
- **Reset values.** `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `wr_valid`=0, `wr_addr`=0. `wr_data` is don't-care while `wr_valid`=0. `gcu_x` follows `rd_data`.
- **Latency** (start sampled at cycle 0):
  - first `rd_en` at cycle 1;
  - first `wr_valid` at cycle 3;
  - with `wr_ready` held at 1, writes occur in cycles 3…N+2 and `done` pulses in cycle N+3.
- **`num_vec`=0.** `done` pulses at cycle 1, with no reads and no writes.
- **Throughput.** 1 vector/cycle at FIFO_DEPTH≥3 and `wr_ready`=1.
- **Simultaneous push and pop.** Both are allowed in the same cycle; occupancy is unchanged.
- **Credit timing.** A pop in cycle t frees a credit only from cycle t+1.
- **Back-pressure.** While `wr_ready`=0, reads stop once credits reach FIFO_DEPTH and resume the cycle after a pop.

## Structure
- **Package `gcu_pkg`.** Holds the `gcu_state_e` enum {IDLE, RUN, DRAIN, DONE}, the lane-count and element-width constants shared with the GCU, and a `gcu_vec_t` typedef (array [NUM_GELU] of signed [W-1:0]).
- **Sub-module `gcu_res_fifo`.** A synchronous FIFO (FIFO_DEPTH × W×NUM_GELU) with count output and push/pop; it has no write-through.
- **Top level.** `gcu_sched` contains the FSM, the counters, credit tracking and address generation. The GCU is instantiated outside this block, at the parent level.

## Test plan
- **Basic run.** `num_vec`=4, `src_base`=0x010, `dst_base`=0x100, `wr_ready`=1, GCU-model bench → reads at addresses 0x010–0x013 in cycles 1–4; writes at 0x100–0x103 in cycles 3–6, with `wr_data` bit-exact to GCU(`rd_data`); `done` in cycle 7.
- **Zero length.** `num_vec`=0 → `done` at cycle 1; `rd_en` and `wr_valid` never assert; `busy` stays 0.
- **Back-pressure.** `num_vec`=8 with `wr_ready` low for cycles 3–10 → at most 3 reads before the stall; `wr_valid`, `wr_addr` and `wr_data` held stable; all 8 results in order; `done` once.
- **Address wrap.** `src_base`=0xFFE, `dst_base`=0xFFF, `num_vec`=3 → reads at 0xFFE, 0xFFF, 0x000; writes at 0xFFF, 0x000, 0x001.
- **Start while busy.** `start` pulsed in cycle 2 of a 4-vector job with different parameters → ignored; the original job completes unchanged.
- **Reset mid-job.** `rst_n`=0 in cycle 4 of an 8-vector job → next cycle all outputs are at their reset values and no `done` appears; a fresh job started afterwards runs normally.
